stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Control sequencer for the two-digit BCD stopwatch. Conditions the four raw push-buttons (synchronize, debounce, one-shot), runs the run/pause/clear state machine, and prescales clk into count ticks. Drives the BCD counter datapath (tick, step size, clear) and exports fsm_state to top for display and debug.

Parameters:
TICK_CYCLES, 10_000_000, clk cycles per count tick (>=2)
DEBOUNCE_CYCLES, 1_000, consecutive synchronized-high cycles before a button counts as pressed (>=1)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
one_button  input  1  raw button: run, +1 per tick
ten_button  input  1  raw button: run, +10 per tick
pause_button  input  1  raw button: pause/resume toggle
clear_button  input  1  raw button: clear count
count_at_max  input  1  datapath count is 99 (used only with the optional feature)
count_tick  output  1  one-cycle pulse: datapath adds step
count_step  output  1  0 = +1, 1 = +10
count_clear  output  1  one-cycle pulse: datapath zeroes count
fsm_state  output  5  one-hot state

Behaviour:
- Reset (async, n_rst=0): fsm_state=5'b00001 (IDLE), count_tick=0, count_step=0, count_clear=0, prescaler=0, all sync/debounce flops=0, saved mode=ONES. Effective immediately, including mid-run.
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter increments while the synchronized input is 1. It clears, and the debounced level clears, in the same cycle the input reads 0.
  - Debounced level sets at the edge where the input has been high for DEBOUNCE_CYCLES consecutive cycles.
  - Press event = debounced level & ~level_q, asserted for exactly 1 cycle per press regardless of hold length.
  - Latency: raw rise before edge 1 -> state register updates at edge DEBOUNCE_CYCLES+3.
  - High pulses shorter than DEBOUNCE_CYCLES produce no event.
- States (one-hot): IDLE=00001, RUN_ONES=00010, RUN_TENS=00100, PAUSED=01000, CLEARING=10000.
- Priority when events coincide: clear > pause > ten > one.
- IDLE:
  - clear -> CLEARING
  - ten -> RUN_TENS
  - one -> RUN_ONES
  - pause ignored
- RUN_ONES / RUN_TENS:
  - clear -> CLEARING
  - pause -> PAUSED
  - the other step button -> other RUN state; prescaler is not reset
  - same step button ignored
- PAUSED:
  - clear -> CLEARING
  - pause -> RUN state of saved mode
  - ten/one -> RUN_TENS/RUN_ONES
- CLEARING: count_clear=1 for exactly this one cycle, then IDLE unconditionally. Button events in this cycle are dropped.
- Saved mode register: updated on every entry to a RUN state. count_step = saved mode (1=TENS), so it holds its value in PAUSED and IDLE.
- Prescaler ($clog2(TICK_CYCLES) bits):
  - Increments only in RUN states.
  - When equal to TICK_CYCLES-1 in a RUN state: count_tick=1 that cycle (combinational from state and prescaler), prescaler wraps to 0.
  - Frozen in PAUSED, so resume completes the partial interval.
  - Forced to 0 in IDLE and CLEARING.
  - First tick after start occurs TICK_CYCLES cycles after RUN entry.
- Tick and a state-changing event in the same cycle: the tick is still issued (based on current state).
- count_tick and count_clear are never both 1.
- Count wrap 99->00 is the datapath's responsibility.

Optional Feature:
STOPWATCH_AUTOSTOP_EN.
- Defined: in a RUN state, if a tick is due and count_at_max=1, count_tick is suppressed, the prescaler wraps, and the next state is PAUSED with saved mode unchanged.
- Undefined: count_at_max is ignored, the tick is issued, and the datapath wraps.

Decomposition:
- Package stopwatch_pkg: one-hot state_t enum (5 bits, encodings above), mode_t (ONES=0, TENS=1), STATE_W=5.
- Sub-module button_debounce (params DEBOUNCE_CYCLES; ports clk, n_rst, btn_raw, press): instantiated 4x inside stopwatch_ctrl.
- FSM and prescaler stay in stopwatch_ctrl.

Test Plan (TICK_CYCLES=10, DEBOUNCE_CYCLES=4):
- Assert n_rst=0 mid-RUN_TENS between edges -> fsm_state=00001, count_step=0, count_tick=0, count_clear=0 immediately; no tick for 10 cycles after release.
- one_button held 30 cycles from IDLE -> fsm_state=00010 at edge 7; count_tick pulses at cycles 10, 20, 30 after entry with count_step=0; exactly one press event.
- Pause when prescaler=6 -> PAUSED 01000, no ticks for 50 cycles; pause again -> RUN_ONES, first tick after 4 cycles.
- ten_button in RUN_ONES at prescaler=3 -> RUN_TENS 00100, count_step=1, next tick 7 cycles later; 3-cycle glitch on clear_button -> no change.
- clear_button and pause_button pressed simultaneously in RUN_TENS -> CLEARING 10000 for one cycle with count_clear=1, then IDLE; count_step stays 1.
- With STOPWATCH_AUTOSTOP_EN defined, count_at_max=1 at a tick -> no count_tick, fsm_state=01000. Without the macro -> count_tick=1, state stays RUN.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch control sequencer: one-hot FSM state
// encoding and the saved step mode.
package stopwatch_pkg;

    localparam int STATE_W = 5;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 5'b00001,
        RUN_ONES = 5'b00010,
        RUN_TENS = 5'b00100,
        PAUSED   = 5'b01000,
        CLEARING = 5'b10000
    } state_t;

    typedef enum logic {
        ONES = 1'b0,
        TENS = 1'b1
    } mode_t;

    function automatic logic is_run(input state_t s);
        return (s == RUN_ONES) || (s == RUN_TENS);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, consecutive-high debounce
// counter and a one-cycle press pulse per debounced rising edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_q;

    // Synchronize, count consecutive high samples, latch the debounced level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            level_q <= level;
            if (!sync_q2) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (!level) begin
                if (cnt == CNT_LAST) begin
                    level <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: four conditioned buttons drive a one-hot
// run/pause/clear FSM; a prescaler turns clk into count ticks for the BCD
// datapath. Optional build macro STOPWATCH_AUTOSTOP_EN pauses at count 99
// instead of letting the datapath wrap.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_CYCLES     = 10_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               one_button,
    input  logic               ten_button,
    input  logic               pause_button,
    input  logic               clear_button,
    input  logic               count_at_max,
    output logic               count_tick,
    output logic               count_step,
    output logic               count_clear,
    output logic [STATE_W-1:0] fsm_state
);

    localparam int PW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    logic          one_press;
    logic          ten_press;
    logic          pause_press;
    logic          clear_press;
    state_t        state;
    state_t        state_nxt;
    mode_t         mode;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic          tick_due;
    logic          at_stop;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_one (
        .clk(clk), .n_rst(n_rst), .btn_raw(one_button), .press(one_press)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ten (
        .clk(clk), .n_rst(n_rst), .btn_raw(ten_button), .press(ten_press)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_pause (
        .clk(clk), .n_rst(n_rst), .btn_raw(pause_button), .press(pause_press)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
        .clk(clk), .n_rst(n_rst), .btn_raw(clear_button), .press(clear_press)
    );

    assign tick_due = is_run(state) && (presc == PRESC_LAST);

`ifdef STOPWATCH_AUTOSTOP_EN
    // A tick that would roll 99 over to 00 is swallowed and the watch pauses.
    assign at_stop = tick_due & count_at_max;
`else
    logic unused_count_at_max;
    assign unused_count_at_max = count_at_max;
    assign at_stop = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; event priority is clear > pause > ten > one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (clear_press)    state_nxt = CLEARING;
                else if (ten_press) state_nxt = RUN_TENS;
                else if (one_press) state_nxt = RUN_ONES;
            end
            RUN_ONES: begin
                if (clear_press)                 state_nxt = CLEARING;
                else if (at_stop || pause_press) state_nxt = PAUSED;
                else if (ten_press)              state_nxt = RUN_TENS;
            end
            RUN_TENS: begin
                if (clear_press)                 state_nxt = CLEARING;
                else if (at_stop || pause_press) state_nxt = PAUSED;
                else if (one_press)              state_nxt = RUN_ONES;
            end
            PAUSED: begin
                if (clear_press)      state_nxt = CLEARING;
                else if (pause_press) state_nxt = (mode == TENS) ? RUN_TENS : RUN_ONES;
                else if (ten_press)   state_nxt = RUN_TENS;
                else if (one_press)   state_nxt = RUN_ONES;
            end
            CLEARING: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs: tick is combinational from state and prescaler, clear from state.
    always_comb begin
        count_tick  = tick_due & ~at_stop;
        count_clear = (state == CLEARING);
        count_step  = (mode == TENS);
        fsm_state   = state;
    end

    // Saved mode follows every entry into a RUN state and holds otherwise.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mode <= ONES;
        end else if (state_nxt == RUN_TENS) begin
            mode <= TENS;
        end else if (state_nxt == RUN_ONES) begin
            mode <= ONES;
        end
    end

    // Prescaler next value: count in RUN, hold in PAUSED, zero elsewhere.
    always_comb begin
        presc_nxt = '0;
        if (is_run(state)) begin
            presc_nxt = tick_due ? '0 : presc + 1'b1;
        end else if (state == PAUSED) begin
            presc_nxt = presc;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            presc <= '0;
        end else begin
            presc <= presc_nxt;
        end
    end

endmodule
